// File: rtl/decode_stage.sv
// RV32I decode stage: classifies fetched beats and hands them to execute
// through a registered two-entry skid buffer (head drives out_*, skid catches overflow).

package opcode_type;
  typedef enum logic [3:0] {
    invalid, lui_type, auipc_type, jal_type, jalr_type, branch_type,
    load_type, store_type, imm_arith, reg_arith, fence_type, system_type
  } opcode_t;

  typedef enum logic [5:0] {
    LUI, AUIPC, JAL, JALR,
    BEQ, BNE, BLT, BGE, BLTU, BGEU,
    LB, LH, LW, LBU, LHU, SB, SH, SW,
    ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI,
    ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
    FENCE, ECALL, EBREAK,
    CSRRW, CSRRS, CSRRC, CSRRWI, CSRRSI, CSRRCI
  } instr_kind_t;
endpackage

module decode_stage
  import opcode_type::*;
#(
  parameter int XLEN          = 32,
  parameter bit STRICT_FUNCT7 = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [31:0]       in_instr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_pc,
  output opcode_t           out_opcode,
  output instr_kind_t       out_kind,
  output logic [4:0]        out_rd,
  output logic [4:0]        out_rs1,
  output logic [4:0]        out_rs2,
  output logic [XLEN-1:0]   out_imm,
  output logic              out_illegal
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    opcode_t         opcode;
    instr_kind_t     kind;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] imm;
    logic            illegal;
  } rec_t;

  localparam rec_t RESET_REC = '{pc: '0, opcode: invalid, kind: LUI, rd: 5'd0,
                                 rs1: 5'd0, rs2: 5'd0, imm: '0, illegal: 1'b0};

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t          state_r, next_s;
  logic            in_ready_r, out_valid_r;
  rec_t            head_r, skid_r, dec_s;
  logic            load_head_s, load_skid_s, head_from_skid_s;
  logic            acc_s, pop_s;

  opcode_t         op_s;
  instr_kind_t     kind_s;
  logic [XLEN-1:0] imm_s, imm_i_s, imm_st_s, imm_b_s, imm_u_s, imm_j_s, shamt_s;
  logic            bad_s, f7_zero_s, f7_alt_s;

  assign imm_i_s   = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_st_s  = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_b_s   = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
  assign imm_u_s   = {in_instr[31:12], 12'd0};
  assign imm_j_s   = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
  assign shamt_s   = {27'd0, in_instr[24:20]};
  assign f7_zero_s = (in_instr[31:25] == 7'b0000000);
  assign f7_alt_s  = (in_instr[31:25] == 7'b0100000);

  // Instruction classification and immediate selection
  always_comb begin
    op_s   = invalid;
    kind_s = LUI;
    imm_s  = '0;
    bad_s  = 1'b0;
    case (in_instr[6:0])
      7'b0110111: begin op_s = lui_type;   kind_s = LUI;   imm_s = imm_u_s; end
      7'b0010111: begin op_s = auipc_type; kind_s = AUIPC; imm_s = imm_u_s; end
      7'b1101111: begin op_s = jal_type;   kind_s = JAL;   imm_s = imm_j_s; end
      7'b1100111: begin
        op_s = jalr_type; kind_s = JALR; imm_s = imm_i_s;
        bad_s = (in_instr[14:12] != 3'b000);
      end
      7'b1100011: begin
        op_s = branch_type; imm_s = imm_b_s;
        case (in_instr[14:12])
          3'b000:  kind_s = BEQ;
          3'b001:  kind_s = BNE;
          3'b100:  kind_s = BLT;
          3'b101:  kind_s = BGE;
          3'b110:  kind_s = BLTU;
          3'b111:  kind_s = BGEU;
          default: bad_s = 1'b1;
        endcase
      end
      7'b0000011: begin
        op_s = load_type; imm_s = imm_i_s;
        case (in_instr[14:12])
          3'b000:  kind_s = LB;
          3'b001:  kind_s = LH;
          3'b010:  kind_s = LW;
          3'b100:  kind_s = LBU;
          3'b101:  kind_s = LHU;
          default: bad_s = 1'b1;
        endcase
      end
      7'b0100011: begin
        op_s = store_type; imm_s = imm_st_s;
        case (in_instr[14:12])
          3'b000:  kind_s = SB;
          3'b001:  kind_s = SH;
          3'b010:  kind_s = SW;
          default: bad_s = 1'b1;
        endcase
      end
      7'b0010011: begin
        op_s = imm_arith; imm_s = imm_i_s;
        case (in_instr[14:12])
          3'b000:  kind_s = ADDI;
          3'b010:  kind_s = SLTI;
          3'b011:  kind_s = SLTIU;
          3'b100:  kind_s = XORI;
          3'b110:  kind_s = ORI;
          3'b111:  kind_s = ANDI;
          3'b001: begin
            kind_s = SLLI; imm_s = shamt_s;
            bad_s  = STRICT_FUNCT7 && !f7_zero_s;
          end
          3'b101: begin
            // imm[11:5] is a function code here, so only the shift amount is kept
            kind_s = in_instr[30] ? SRAI : SRLI; imm_s = shamt_s;
            bad_s  = STRICT_FUNCT7 && !(f7_zero_s || f7_alt_s);
          end
          default: bad_s = 1'b1;
        endcase
      end
      7'b0110011: begin
        op_s = reg_arith;
        case (in_instr[14:12])
          3'b000: begin
            kind_s = in_instr[30] ? SUB : ADD;
            bad_s  = STRICT_FUNCT7 && !(f7_zero_s || f7_alt_s);
          end
          3'b101: begin
            kind_s = in_instr[30] ? SRA : SRL;
            bad_s  = STRICT_FUNCT7 && !(f7_zero_s || f7_alt_s);
          end
          3'b001:  begin kind_s = SLL;  bad_s = STRICT_FUNCT7 && !f7_zero_s; end
          3'b010:  begin kind_s = SLT;  bad_s = STRICT_FUNCT7 && !f7_zero_s; end
          3'b011:  begin kind_s = SLTU; bad_s = STRICT_FUNCT7 && !f7_zero_s; end
          3'b100:  begin kind_s = XOR;  bad_s = STRICT_FUNCT7 && !f7_zero_s; end
          3'b110:  begin kind_s = OR;   bad_s = STRICT_FUNCT7 && !f7_zero_s; end
          3'b111:  begin kind_s = AND;  bad_s = STRICT_FUNCT7 && !f7_zero_s; end
          default: bad_s = 1'b1;
        endcase
      end
      7'b0001111: begin
        op_s = fence_type; kind_s = FENCE;
        bad_s = (in_instr[14:12] != 3'b000);
      end
      7'b1110011: begin
        op_s = system_type; imm_s = imm_i_s;
        case (in_instr[14:12])
          3'b000: begin
            if (in_instr == 32'h0000_0073) begin
              kind_s = ECALL;
            end else if (in_instr == 32'h0010_0073) begin
              kind_s = EBREAK;
            end else begin
              bad_s = 1'b1;
            end
          end
          3'b001:  kind_s = CSRRW;
          3'b010:  kind_s = CSRRS;
          3'b011:  kind_s = CSRRC;
          3'b101:  kind_s = CSRRWI;
          3'b110:  kind_s = CSRRSI;
          3'b111:  kind_s = CSRRCI;
          default: bad_s = 1'b1;
        endcase
      end
      default: bad_s = 1'b1;
    endcase
  end

  // Assemble the decoded record; illegal words keep their register fields
  always_comb begin
    dec_s     = RESET_REC;
    dec_s.pc  = in_pc;
    dec_s.rd  = in_instr[11:7];
    dec_s.rs1 = in_instr[19:15];
    dec_s.rs2 = in_instr[24:20];
    if (bad_s || (in_instr[1:0] != 2'b11)) begin
      dec_s.opcode  = invalid;
      dec_s.kind    = LUI;
      dec_s.imm     = '0;
      dec_s.illegal = 1'b1;
    end else begin
      dec_s.opcode  = op_s;
      dec_s.kind    = kind_s;
      dec_s.imm     = imm_s;
      dec_s.illegal = 1'b0;
    end
  end

  assign acc_s = in_valid && in_ready_r;
  assign pop_s = out_valid_r && out_ready;

  // Occupancy next-state and buffer load controls
  always_comb begin
    next_s           = state_r;
    load_head_s      = 1'b0;
    load_skid_s      = 1'b0;
    head_from_skid_s = 1'b0;
    if (flush) begin
      next_s = EMPTY;
    end else begin
      case (state_r)
        EMPTY: begin
          if (acc_s) begin
            next_s = ONE; load_head_s = 1'b1;
          end else begin
            next_s = EMPTY;
          end
        end
        ONE: begin
          if (acc_s && !pop_s) begin
            next_s = TWO; load_skid_s = 1'b1;
          end else if (!acc_s && pop_s) begin
            next_s = EMPTY;
          end else if (acc_s && pop_s) begin
            next_s = ONE; load_head_s = 1'b1;
          end else begin
            next_s = ONE;
          end
        end
        TWO: begin
          if (pop_s) begin
            next_s = ONE; head_from_skid_s = 1'b1;
          end else begin
            next_s = TWO;
          end
        end
        default: next_s = EMPTY;
      endcase
    end
  end

  // State register with registered handshake flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= EMPTY;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= next_s;
      in_ready_r  <= (next_s != TWO);
      out_valid_r <= (next_s != EMPTY);
    end
  end

  // Head and skid entry storage
  always_ff @(posedge clk) begin
    if (rst) begin
      head_r <= RESET_REC;
      skid_r <= RESET_REC;
    end else begin
      if (load_head_s) begin
        head_r <= dec_s;
      end else if (head_from_skid_s) begin
        head_r <= skid_r;
      end else begin
        head_r <= head_r;
      end
      if (load_skid_s) begin
        skid_r <= dec_s;
      end else begin
        skid_r <= skid_r;
      end
    end
  end

  assign in_ready    = in_ready_r;
  assign out_valid   = out_valid_r;
  assign out_pc      = head_r.pc;
  assign out_opcode  = head_r.opcode;
  assign out_kind    = head_r.kind;
  assign out_rd      = head_r.rd;
  assign out_rs1     = head_r.rs1;
  assign out_rs2     = head_r.rs2;
  assign out_imm     = head_r.imm;
  assign out_illegal = head_r.illegal;

endmodule
